// File: rtl/graph_plot_if.sv
// graph_plot_if: start/complete control, point-slot read port and pixel handshake
// between the graph generator, the plot controller and the framebuffer writer.
interface graph_plot_if #(parameter int IDX_W = 6);
    logic             start;
    logic             graph_complete;
    logic [IDX_W-1:0] pt_idx;
    logic [31:0]      pt_x;
    logic [31:0]      pt_y;
    logic             px_valid;
    logic             px_ready;
    logic [9:0]       px_x;
    logic [8:0]       px_y;
    logic             busy;
    logic             done;
    logic [IDX_W:0]   clip_cnt;
    modport master (
        output start, graph_complete, pt_x, pt_y, px_ready,
        input  pt_idx, px_valid, px_x, px_y, busy, done, clip_cnt
    );
    modport slave (
        input  start, graph_complete, pt_x, pt_y, px_ready,
        output pt_idx, px_valid, px_x, px_y, busy, done, clip_cnt
    );
endinterface

// File: rtl/graph_plot_ctrl.sv
// graph_plot_ctrl: walks the point slots, maps each point to screen coordinates,
// clips off-screen points and emits the rest on a valid/ready pixel handshake.
module graph_plot_ctrl #(
    parameter int N_PTS   = 64,
    parameter int IDX_W   = 6,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int X_SHIFT = 0,
    parameter int Y_SHIFT = 0,
    parameter int X_OFF   = 320,
    parameter int Y_OFF   = 240
) (
    input logic           clk,
    input logic           rst,
    graph_plot_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, WAIT_CPL, FETCH, LATCH, EMIT, FIN} state_t;
    localparam logic signed [32:0] XO = 33'(X_OFF);
    localparam logic signed [32:0] YO = 33'(Y_OFF);
    localparam logic signed [32:0] SW = 33'(SCR_W);
    localparam logic signed [32:0] SH = 33'(SCR_H);
    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W:0]     clip_cnt;
    logic               px_valid;
    logic [9:0]         px_x;
    logic [8:0]         px_y;
    logic signed [32:0] sx, sy;
    logic               on_scr, last, hs;
    // Sign-extend to 33 bits so the offset can never wrap.
    assign sx     = ($signed({bus.pt_x[31], bus.pt_x}) >>> X_SHIFT) + XO;
    assign sy     = YO - ($signed({bus.pt_y[31], bus.pt_y}) >>> Y_SHIFT);
    assign on_scr = !sx[32] && sx < SW && !sy[32] && sy < SH;
    assign last   = idx == IDX_W'(N_PTS - 1);
    assign hs     = px_valid & bus.px_ready;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = bus.start ? WAIT_CPL : IDLE;
            WAIT_CPL: state_nx = bus.graph_complete ? FETCH : WAIT_CPL;
            FETCH:    state_nx = LATCH;
            LATCH:    state_nx = on_scr ? EMIT : (last ? FIN : FETCH);
            EMIT:     state_nx = hs ? (last ? FIN : FETCH) : EMIT;
            FIN:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    // Index wraps to 0 after the last slot since N_PTS is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            clip_cnt <= '0;
            px_valid <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                idx      <= '0;
                clip_cnt <= '0;
            end
            if (state == LATCH && on_scr) begin
                px_x     <= sx[9:0];
                px_y     <= sy[8:0];
                px_valid <= 1'b1;
            end
            if (state == LATCH && !on_scr) begin
                clip_cnt <= clip_cnt + 1'b1;
                idx      <= idx + 1'b1;
            end
            if (state == EMIT && hs) begin
                px_valid <= 1'b0;
                idx      <= idx + 1'b1;
            end
        end
    end
    assign bus.pt_idx   = idx;
    assign bus.px_valid = px_valid;
    assign bus.px_x     = px_x;
    assign bus.px_y     = px_y;
    assign bus.clip_cnt = clip_cnt;
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == FIN;
endmodule

// File: tb/tb_graph_plot_ctrl.sv
// tb_graph_plot_ctrl: scoreboard bench; expected pixels come from a plain-arithmetic
// model of the screen mapping and are popped by an independent handshake monitor.
module tb_graph_plot_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    graph_plot_if #(.IDX_W(6)) bus ();
    graph_plot_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    int mem_x[64], mem_y[64];
    int exp_x[$], exp_y[$];
    int clips, done_seen, v323, cyc = 0, last_cyc;
    int rdy_mode = 0;
    bit gap_en = 0, first_hs = 1, pending = 0;
    logic [9:0] hx;
    logic [8:0] hy;
    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, act, exp);
        end
    endtask
    function automatic bit model(input int x, input int y, output int ox, output int oy);
        longint sx, sy;
        sx = (longint'(x) >>> 0) + 320;
        sy = 240 - (longint'(y) >>> 0);
        ox = int'(sx);
        oy = int'(sy);
        return sx >= 0 && sx < 640 && sy >= 0 && sy < 480;
    endfunction
    always @(posedge clk) begin
        cyc++;
        bus.pt_x <= mem_x[bus.pt_idx];
        bus.pt_y <= mem_y[bus.pt_idx];
    end
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1: bus.px_ready = 1'($urandom_range(0, 1));
            2: if (bus.px_valid && bus.px_x == 10'd323 && v323 < 5) bus.px_ready = 1'b0;
               else bus.px_ready = 1'b1;
            3: bus.px_ready = !(bus.px_valid && bus.px_x == 10'd327);
            default: bus.px_ready = 1'b1;
        endcase
    end
    always @(negedge clk) if (!rst) begin
        if (bus.done) done_seen++;
        if (bus.px_valid) begin
            if (bus.px_x == 10'd323) v323++;
            if (pending) begin
                chk("hold_x", bus.px_x, hx);
                chk("hold_y", bus.px_y, hy);
            end
            if (bus.px_ready) begin
                if (exp_x.size() == 0) chk("extra_px", 1, 0);
                else begin
                    chk("px_x", bus.px_x, exp_x.pop_front());
                    chk("px_y", bus.px_y, exp_y.pop_front());
                end
                if (gap_en && !first_hs) chk("gap", cyc - last_cyc, 3);
                first_hs = 0;
                last_cyc = cyc;
                pending  = 0;
            end else begin
                pending = 1;
                hx = bus.px_x;
                hy = bus.px_y;
            end
        end
    end
    task automatic prep();
        int ox, oy;
        exp_x.delete();
        exp_y.delete();
        clips = 0;
        for (int i = 0; i < 64; i++)
            if (model(mem_x[i], mem_y[i], ox, oy)) begin
                exp_x.push_back(ox);
                exp_y.push_back(oy);
            end else clips++;
        done_seen = 0;
        first_hs  = 1;
        pending   = 0;
        v323      = 0;
    endtask
    task automatic go();
        @(posedge clk); #1 bus.start = 1; bus.graph_complete = 1;
        @(posedge clk); #1 bus.start = 0;
        @(posedge clk); #1 bus.graph_complete = 0;
    endtask
    task automatic wait_done();
        int c = 0;
        while (done_seen == 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        chk("done_seen", done_seen != 0, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", done_seen, 1);
        chk("clip_cnt", bus.clip_cnt, clips);
        chk("left_in_q", exp_x.size(), 0);
        chk("busy_after", bus.busy, 0);
    endtask
    task automatic run(input int mode, input bit gap);
        rdy_mode = mode;
        gap_en   = gap;
        prep();
        go();
        wait_done();
    endtask
    task automatic ramp();
        for (int i = 0; i < 64; i++) begin
            mem_x[i] = i;
            mem_y[i] = i;
        end
    endtask
    initial begin
        int c;
        bit ok;
        bus.start = 0;
        bus.graph_complete = 0;
        bus.px_ready = 1;
        ramp();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.px_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_idx", bus.pt_idx, 0);
        chk("rst_clip", bus.clip_cnt, 0);
        chk("rst_pxx", bus.px_x, 0);
        chk("rst_pxy", bus.px_y, 0);
        rst = 0;
        run(0, 1);
        run(2, 0);
        chk("stall_cycles", v323, 6);
        ramp();
        for (int i = 10; i < 20; i++) mem_x[i] = 400;
        run(0, 0);
        chk("clip10", clips, 10);
        ramp();
        mem_x[0] = -320; mem_y[0] = 0;
        mem_y[1] = -240;
        mem_x[2] = 319;
        mem_x[3] = 320;
        mem_y[4] = 240;
        mem_y[5] = -239;
        run(0, 0);
        for (int i = 0; i < 64; i++) begin
            mem_x[i] = $urandom_range(0, 680) - 340;
            mem_y[i] = $urandom_range(0, 500) - 250;
        end
        run(1, 0);
        ramp();
        rdy_mode = 0;
        gap_en = 1;
        prep();
        @(posedge clk); #1 bus.start = 1;
        @(posedge clk); #1 bus.start = 0;
        chk("busy_wait", bus.busy, 1);
        ok = 1;
        for (int k = 0; k < 44; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 14);
            if (bus.pt_idx != 0 || bus.px_valid || !bus.busy) ok = 0;
        end
        bus.start = 0;
        chk("wait_hold", ok, 1);
        bus.graph_complete = 1;
        @(posedge clk); #1 bus.graph_complete = 0;
        repeat (148) @(posedge clk);
        #1 bus.start = 1;
        chk("busy_mid", bus.busy, 1);
        @(posedge clk); #1 bus.start = 0;
        wait_done();
        ramp();
        mem_x[2] = 400;
        rdy_mode = 3;
        gap_en = 0;
        prep();
        go();
        c = 0;
        while (!(bus.px_valid && bus.px_x == 10'd327) && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("reach_pt7", c < 500, 1);
        chk("clip_pre_rst", bus.clip_cnt, 1);
        #1 rst = 1;
        #1;
        chk("arst_valid", bus.px_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_idx", bus.pt_idx, 0);
        chk("arst_clip", bus.clip_cnt, 0);
        @(posedge clk); #1 rst = 0;
        run(0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
